// File: rtl/mm_tile_pkg.sv
// mm_tile_pkg: shared types and constants for the matrix-multiply tile sequencer.
//   state_t       - sequencer FSM states
//   imax / imin   - constant-evaluable helpers for deriving lengths from parameters
//   flush_cycles  - pipeline flush length for a given array shape and MAC latencies
//   FLUSH_CYC, FEED_MAX, T_W_DEF, AUX_W_DEF - values for the default 4x4 array
package mm_tile_pkg;

  localparam int ROWS_DEF     = 4;
  localparam int COLS_DEF     = 4;
  localparam int MULT_LAT_DEF = 1;
  localparam int ACC_LAT_DEF  = 1;
  localparam int K_MAX_DEF    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // The last operand pair enters the far corner of the shorter array edge,
  // then has to pass the multiplier and the accumulator.
  function automatic int flush_cycles(input int rows, input int cols,
                                      input int mult_lat, input int acc_lat);
    return imin(rows, cols) - 1 + mult_lat + acc_lat;
  endfunction

  localparam int FLUSH_CYC = flush_cycles(ROWS_DEF, COLS_DEF, MULT_LAT_DEF, ACC_LAT_DEF);
  localparam int FEED_MAX  = K_MAX_DEF + imax(ROWS_DEF, COLS_DEF) - 1;

  // Step counter carries one extra bit so k_len+lanes-2 never wraps.
  localparam int T_W_DEF   = $clog2(K_MAX_DEF + 1) + 1;
  // Shared flush/drain counter must reach the larger of the two lengths.
  localparam int AUX_W_DEF = $clog2(imax(FLUSH_CYC, ROWS_DEF) + 1);

endpackage

// File: rtl/skew_lane_gen.sv
// skew_lane_gen: read enable / address for one operand-buffer lane.
//   t           in  KW+1    current feed step
//   k_len       in  KW      inner dimension of the tile
//   feed_active in  1       sequencer is feeding
//   en          out 1       lane read enable, high for LANE <= t < LANE+k_len
//   addr        out ADDR_W  t-LANE while enabled, otherwise 0
// Purely combinational; the sequencer registers the results.
module skew_lane_gen
  import mm_tile_pkg::*;
#(
  parameter int LANE   = 0,
  parameter int ADDR_W = 4,
  parameter int KW     = 5
) (
  input  logic [KW:0]       t,
  input  logic [KW-1:0]     k_len,
  input  logic              feed_active,
  output logic              en,
  output logic [ADDR_W-1:0] addr
);

  // One bit wider than t so LANE+k_len cannot overflow.
  localparam logic [KW+1:0] LANE_W = (KW+2)'(LANE);

  logic [KW+1:0] t_w;
  logic [KW+1:0] end_w;

  always_comb begin
    t_w   = {1'b0, t};
    end_w = {2'b00, k_len} + LANE_W;
    en    = feed_active && (t_w >= LANE_W) && (t_w < end_w);
    addr  = '0;
    // Only subtract when enabled, where t >= LANE holds.
    if (en) begin
      addr = ADDR_W'(t_w - LANE_W);
    end
  end

endmodule

// File: rtl/mm_tile_seq.sv
// mm_tile_seq: sequencer for one matrix-multiply tile on a ROWS x COLS MAC array.
//   clk, rst (sync, active-low)
//   start, k_len         - tile request; k_len legal in 1..K_MAX
//   busy, done, cfg_err  - status; done/cfg_err are single-cycle pulses
//   a_rd_en, a_rd_addr   - skewed per-row A buffer reads
//   b_rd_en, b_rd_addr   - skewed per-column B buffer reads
//   acc_rst              - accumulator clear, high only in CLEAR
//   stream_out_rdy       - result drain handshake, out_ready gated by DRAIN
//   out_ready            - downstream sink ready
module mm_tile_seq
  import mm_tile_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int ACC_LAT  = ACC_LAT_DEF,
  parameter int K_MAX    = K_MAX_DEF,
  parameter int ADDR_W   = $clog2(K_MAX),
  parameter int KW       = $clog2(K_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic [ROWS-1:0]        a_rd_en,
  output logic [ROWS*ADDR_W-1:0] a_rd_addr,
  output logic [COLS-1:0]        b_rd_en,
  output logic [COLS*ADDR_W-1:0] b_rd_addr,
  output logic                   acc_rst,
  output logic                   stream_out_rdy,
  input  logic                   out_ready
);

  localparam int LANE_MAX = imax(ROWS, COLS);
  localparam int FLUSH_N  = flush_cycles(ROWS, COLS, MULT_LAT, ACC_LAT);
  localparam int T_W      = KW + 1;
  localparam int AUX_W    = $clog2(imax(FLUSH_N, ROWS) + 1);

  state_t             state_reg, state_next;
  logic [T_W-1:0]     t_reg, t_next;
  logic [AUX_W-1:0]   aux_reg, aux_next;   // flush cycles, then drain beats
  logic [KW-1:0]      k_reg, k_next;
  logic               cfg_err_next;
  logic               feed_next;
  logic [T_W-1:0]     feed_last;           // one past the final feed step

  logic [ROWS-1:0]        a_en_next;
  logic [ROWS*ADDR_W-1:0] a_addr_next;
  logic [COLS-1:0]        b_en_next;
  logic [COLS*ADDR_W-1:0] b_addr_next;

  assign feed_last = {1'b0, k_reg} + T_W'(LANE_MAX - 1);
  assign feed_next = (state_next == S_FEED);

  always_comb begin
    state_next   = state_reg;
    t_next       = t_reg;
    aux_next     = aux_reg;
    k_next       = k_reg;
    cfg_err_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if ((k_len != '0) && (k_len <= KW'(K_MAX))) begin
            k_next     = k_len;
            state_next = S_CLEAR;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        state_next = S_FEED;
        t_next     = '0;
      end
      S_FEED: begin
        if (t_reg == feed_last - T_W'(1)) begin
          state_next = S_FLUSH;
          t_next     = '0;
          aux_next   = '0;
        end else begin
          t_next = t_reg + T_W'(1);
        end
      end
      S_FLUSH: begin
        if (aux_reg == AUX_W'(FLUSH_N - 1)) begin
          state_next = S_DRAIN;
          aux_next   = '0;
        end else begin
          aux_next = aux_reg + AUX_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (aux_reg == AUX_W'(ROWS - 1)) begin
            state_next = S_DONE;
            aux_next   = '0;
          end else begin
            aux_next = aux_reg + AUX_W'(1);
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Lanes are evaluated on next-state values so the registered enables line
  // up with the state they belong to.
  genvar gi;
  for (gi = 0; gi < ROWS; gi++) begin : g_a_lane
    skew_lane_gen #(.LANE(gi), .ADDR_W(ADDR_W), .KW(KW)) u_lane (
      .t           (t_next),
      .k_len       (k_next),
      .feed_active (feed_next),
      .en          (a_en_next[gi]),
      .addr        (a_addr_next[gi*ADDR_W +: ADDR_W])
    );
  end
  for (gi = 0; gi < COLS; gi++) begin : g_b_lane
    skew_lane_gen #(.LANE(gi), .ADDR_W(ADDR_W), .KW(KW)) u_lane (
      .t           (t_next),
      .k_len       (k_next),
      .feed_active (feed_next),
      .en          (b_en_next[gi]),
      .addr        (b_addr_next[gi*ADDR_W +: ADDR_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      t_reg     <= '0;
      aux_reg   <= '0;
      k_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      acc_rst   <= 1'b0;
      a_rd_en   <= '0;
      a_rd_addr <= '0;
      b_rd_en   <= '0;
      b_rd_addr <= '0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      aux_reg   <= aux_next;
      k_reg     <= k_next;
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_DONE);
      cfg_err   <= cfg_err_next;
      acc_rst   <= (state_next == S_CLEAR);
      a_rd_en   <= a_en_next;
      a_rd_addr <= a_addr_next;
      b_rd_en   <= b_en_next;
      b_rd_addr <= b_addr_next;
    end
  end

  assign stream_out_rdy = (state_reg == S_DRAIN) && out_ready;

endmodule
